spi_mram_master: RTL and testbench

SPI mode-0 master that issues MRAM command frames to the board's SPI MRAM slave and returns read data to a local host. It sits on the initiating FPGA between host logic and the four SPI pins. Each transfer is one SSEL-low frame: an info byte, three address bytes, then 2 bytes per word (written on MOSI, or clocked in from MISO). Single or burst transfers of 1–15 words are supported.

---
 rtl/spi_mram_pkg.sv | 18 +
 rtl/spi_mram_master_shifter.sv | 64 ++++++
 rtl/spi_mram_master.sv | 179 +++++++++++++++++
 tb/tb_spi_mram_master.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_mram_pkg.sv
// spi_mram_pkg: shared FSM states, info-byte layout and frame constants for the SPI MRAM master.
package spi_mram_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP, ST_END, ST_COOLDOWN} state_e;
  localparam logic RW_WRITE = 1'b1;
  localparam int RWS_HI = 7;
  localparam int RWS_LO = 5;
  localparam int LEN_HI = 4;
  localparam int LEN_LO = 1;
  localparam int BEN_BIT = 0;
  localparam int ADDR_BYTES = 3;
  localparam int WORD_BYTES = 2;
  function automatic logic [7:0] info_byte(input logic rw, input logic [3:0] len, input logic ben);
    info_byte = '0;
    info_byte[RWS_HI:RWS_LO] = {2'b00, rw};
    info_byte[LEN_HI:LEN_LO] = len;
    info_byte[BEN_BIT] = ben;
  endfunction
endpackage

// File: rtl/spi_mram_master_shifter.sv
// spi_bit_shifter: mode-0 SCLK divider that shifts one byte out MSB first and collects MISO bits LSB first.
module spi_bit_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       last_o,
  output logic [7:0] rx_o,
  output logic       rx_done_o
);
  localparam int DW = $clog2(CLK_DIV);
  logic          act_q, sclk_q, mosi_q, rxd_q;
  logic [2:0]    bit_q;
  logic [DW-1:0] div_q;
  logic [7:0]    sh_q, rx_q;
  logic          half_end;
  assign half_end  = act_q && div_q == DW'(CLK_DIV - 1);
  assign last_o    = half_end && sclk_q && bit_q == 3'd7;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign rx_o      = rx_q;
  assign rx_done_o = rxd_q;
  // first arrival ends up in rx_q[0] after eight right shifts
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      act_q  <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rxd_q  <= 1'b0;
      bit_q  <= '0;
      div_q  <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      rxd_q <= 1'b0;
      if (load_i) begin
        act_q  <= 1'b1;
        sclk_q <= 1'b0;
        div_q  <= '0;
        bit_q  <= '0;
        mosi_q <= tx_i[7];
        sh_q   <= {tx_i[6:0], 1'b0};
      end else if (act_q) begin
        div_q <= half_end ? '0 : div_q + 1'b1;
        if (half_end && !sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {miso_i, rx_q[7:1]};
          rxd_q  <= bit_q == 3'd7;
        end
        if (half_end && sclk_q) begin
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 3'd1;
          mosi_q <= bit_q == 3'd7 ? 1'b0 : sh_q[7];
          sh_q   <= {sh_q[6:0], 1'b0};
          act_q  <= bit_q != 3'd7;
        end
      end
    end
endmodule

// File: rtl/spi_mram_master.sv
// spi_mram_master: sequences info, address and data bytes of one SSEL-low MRAM frame over SPI mode 0.
module spi_mram_master
  import spi_mram_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 32,
  parameter int SS_IDLE    = 32
) (
  input  logic        FPGA_clk,
  input  logic        FPGA_rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic        burst_en,
  input  logic [3:0]  burst_len,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  output logic        wdata_take,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        SSEL,
  output logic        MOSI,
  input  logic        MISO
);
  localparam int CW = $clog2(GAP_CYCLES > SS_IDLE ? GAP_CYCLES : SS_IDLE) + 1;
  localparam logic [5:0] DATA0 = 6'(1 + ADDR_BYTES);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]  byte_q, byte_d;
  logic [3:0]  word_q, word_d, len_q, len_d, n_words;
  logic        rw_q, rw_d, ben_q, ben_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  rlo_q, rlo_d, tx, rx;
  logic        rvalid_q, rvalid_d, done_q, done_d, ssel_q, ssel_d;
  logic        load, shift_last, rx_done, gap_last, data_byte;
  spi_bit_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_i    (FPGA_clk),
    .rst_ni   (FPGA_rst_n),
    .load_i   (load),
    .tx_i     (tx),
    .miso_i   (MISO),
    .sclk_o   (SCLK),
    .mosi_o   (MOSI),
    .last_o   (shift_last),
    .rx_o     (rx),
    .rx_done_o(rx_done)
  );
  assign n_words     = (ben_q && len_q > 4'd1) ? len_q : 4'd1;
  assign gap_last    = cnt_q == CW'(GAP_CYCLES - 1);
  assign data_byte   = byte_q >= DATA0;
  assign busy        = state_q != ST_IDLE;
  assign done        = done_q;
  assign SSEL        = ssel_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  // byte_q is the index of the byte about to be loaded; even data bytes are word low halves
  assign tx = byte_q == 6'd0 ? info_byte(rw_q, len_q, ben_q) :
              byte_q == 6'd1 ? addr_q[7:0] :
              byte_q == 6'd2 ? addr_q[15:8] :
              byte_q == 6'd3 ? {4'h0, addr_q[19:16]} :
              rw_q != RW_WRITE ? 8'h00 :
              byte_q[0] ? wdata_q[15:8] :
              word_q == 4'd0 ? wdata_q[7:0] : wdata[7:0];
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    word_d     = word_q;
    rw_d       = rw_q;
    ben_d      = ben_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rlo_d      = rlo_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    ssel_d     = ssel_q;
    load       = 1'b0;
    wdata_take = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SETUP;
        cnt_d   = '0;
        byte_d  = '0;
        word_d  = '0;
        rw_d    = rw;
        ben_d   = burst_en;
        len_d   = burst_len;
        addr_d  = addr;
        ssel_d  = 1'b0;
        if (rw == RW_WRITE) begin
          wdata_d    = wdata;
          wdata_take = 1'b1;
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_last) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_SHIFT: if (shift_last) begin
        state_d = ST_GAP;
        byte_d  = byte_q + 6'd1;
        if (data_byte && byte_q[0]) word_d = word_q + 4'd1;
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_last) begin
          cnt_d = '0;
          if (word_q == n_words) begin
            state_d = ST_END;
            ssel_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            load    = 1'b1;
          end
        end
      end
      ST_END: begin
        state_d = ST_COOLDOWN;
        cnt_d   = '0;
      end
      ST_COOLDOWN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SS_IDLE - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load && rw_q == RW_WRITE && data_byte && !byte_q[0] && word_q != 4'd0) begin
      wdata_take = 1'b1;
      wdata_d    = wdata;
    end
    if (rx_done && state_q == ST_SHIFT && rw_q != RW_WRITE && data_byte) begin
      rlo_d    = byte_q[0] ? rlo_q : rx;
      rdata_d  = byte_q[0] ? {rx, rlo_q} : rdata_q;
      rvalid_d = byte_q[0];
    end
  end
  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n)
    if (!FPGA_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      rw_q     <= 1'b0;
      ben_q    <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rlo_q    <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ssel_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      rw_q     <= rw_d;
      ben_q    <= ben_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rlo_q    <= rlo_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      ssel_q   <= ssel_d;
    end
endmodule

// File: tb/tb_spi_mram_master.sv
// tb_spi_mram_master: directed frames against an SPI slave model that records MOSI bytes and serves MISO words.
module tb_spi_mram_master;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0, ben = 1'b0;
  logic [3:0] blen = '0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
  logic wdata_take, rdata_valid, busy, done, SCLK, SSEL, MOSI, MISO;
  logic [15:0] rdata;
  int n_checks = 0, n_err = 0;
  int n_take = 0, n_done = 0, frames = 0, cur = 0, last_low = 0, nrv = 0, nbits = 0, nbytes = 0;
  int b_take, b_done, b_frames;
  logic ssel_p = 1'b1;
  logic [7:0] sr = '0;
  logic [7:0] cap [64];
  logic [15:0] rdw [16];
  logic [15:0] mw [16];

  always #5 clk = ~clk;

  spi_mram_master #(.CLK_DIV(4), .GAP_CYCLES(32), .SS_IDLE(32)) dut (
    .FPGA_clk(clk), .FPGA_rst_n(rst_n), .start(start), .rw(rw), .burst_en(ben),
    .burst_len(blen), .addr(addr), .wdata(wdata), .wdata_take(wdata_take),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
  );

  // slave model: data bit j of the frame returns bit j%16 of word j/16, LSB first
  assign MISO = (nbits >= 32 && nbits < 288) ? mw[(nbits - 32) / 16][(nbits - 32) % 16] : 1'b0;

  always @(posedge SCLK or negedge SSEL)
    if (!SCLK) begin
      nbits = 0;
      nbytes = 0;
    end else begin
      sr = {sr[6:0], MOSI};
      nbits++;
      if (nbits % 8 == 0 && nbytes < 64) begin
        cap[nbytes] = sr;
        nbytes++;
      end
    end

  always @(negedge clk) begin
    n_take += int'(wdata_take);
    n_done += int'(done);
    if (rdata_valid) begin
      rdw[nrv % 16] = rdata;
      nrv++;
    end
    if (!SSEL) begin
      if (ssel_p) begin
        cur = 0;
        frames++;
        nrv = 0;
      end
      cur++;
    end else if (!ssel_p) last_low = cur;
    ssel_p = SSEL;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic r, input logic b, input logic [3:0] l, input logic [19:0] a);
    b_take = n_take;
    b_done = n_done;
    b_frames = frames;
    @(negedge clk);
    rw = r; ben = b; blen = l; addr = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    check("idle_bound", busy, 1'b0);
  endtask

  task automatic wait_take();
    int i;
    for (i = 0; i < 5000 && !wdata_take; i++) @(negedge clk);
    check("take_bound", wdata_take, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [79:0] v, input int n);
    check({tag, "_nbytes"}, nbytes, n);
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), cap[i], v[8 * (n - 1 - i) +: 8]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mw[i] = '0;
    #12;
    check("rst_ssel", SSEL, 1'b1);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_take", wdata_take, 1'b0);
    check("rst_rvalid", rdata_valid, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single write, with a second start pulsed mid-frame that must be ignored
    wdata = 16'hBEEF;
    send(1'b1, 1'b0, 4'd0, 20'h12345);
    check("sw_ssel_low", SSEL, 1'b0);
    check("sw_busy", busy, 1'b1);
    wdata = 16'h0000;
    repeat (300) @(negedge clk);
    rw = 1'b0; addr = 20'hFFFFF; blen = 4'd7; ben = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk_frame("sw", 80'h20_45_23_01_EF_BE, 6);
    check("sw_takes", n_take - b_take, 1);
    check("sw_dones", n_done - b_done, 1);
    check("sw_frames", frames - b_frames, 1);
    check("sw_len", last_low, 32 + 6 * 96);

    // burst write of three words
    wdata = 16'h1111;
    send(1'b1, 1'b1, 4'd3, 20'h00010);
    wdata = 16'h2222;
    wait_take();
    wdata = 16'h3333;
    wait_idle();
    chk_frame("bw", 80'h27_10_00_00_11_11_22_22_33_33, 10);
    check("bw_takes", n_take - b_take, 3);
    check("bw_dones", n_done - b_done, 1);
    check("bw_len", last_low, 32 + 10 * 96);

    // single read
    mw[0] = 16'hA5C3;
    send(1'b0, 1'b0, 4'd0, 20'h00000);
    wait_idle();
    chk_frame("sr", 80'h00_00_00_00_00_00, 6);
    check("sr_nvalid", nrv, 1);
    check("sr_word", rdw[0], 16'hA5C3);
    check("sr_rdata_held", rdata, 16'hA5C3);
    check("sr_take", n_take - b_take, 0);

    // burst read of two words
    mw[0] = 16'h1234;
    mw[1] = 16'hFEDC;
    send(1'b0, 1'b1, 4'd2, 20'hFFFFF);
    wait_idle();
    chk_frame("br", 80'h05_FF_FF_0F_00_00_00_00, 8);
    check("br_nvalid", nrv, 2);
    check("br_w0", rdw[0], 16'h1234);
    check("br_w1", rdw[1], 16'hFEDC);

    // burst enabled with length 0 still moves one word
    mw[0] = 16'h0F0F;
    send(1'b0, 1'b1, 4'd0, 20'h00001);
    wait_idle();
    chk_frame("b0", 80'h01_01_00_00_00_00, 6);
    check("b0_nvalid", nrv, 1);
    check("b0_word", rdw[0], 16'h0F0F);

    // reset in the middle of the address bytes
    wdata = 16'hBEEF;
    send(1'b1, 1'b0, 4'd0, 20'h12345);
    for (int i = 0; i < 2000 && nbytes < 2; i++) @(negedge clk);
    check("rr_reach", nbytes >= 2, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rr_ssel", SSEL, 1'b1);
    check("rr_sclk", SCLK, 1'b0);
    check("rr_busy", busy, 1'b0);
    #20;
    check("rr_nodone", n_done - b_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wdata = 16'h55AA;
    send(1'b1, 1'b0, 4'd0, 20'h0F00A);
    wait_idle();
    chk_frame("rr", 80'h20_0A_F0_00_AA_55, 6);
    check("rr_dones", n_done - b_done, 1);
    check("rr_len", last_low, 32 + 6 * 96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
